// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//
// Streaming RV32I instruction encoder. Each accepted field-level descriptor
// becomes one 32-bit machine word, or NOP_WORD with out_error set if the
// descriptor is illegal. The result is registered, so it appears one cycle
// after acceptance. The input and output use a valid/ready handshake with
// full throughput of one word per cycle.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   in_valid/ready   descriptor handshake; accept = in_valid && in_ready
//   in_class         0 LOAD, 1 OP-IMM, 2 AUIPC, 3 STORE, 4 OP, 5 LUI,
//                    6 BRANCH, 7 JALR, 8 JAL, 9-15 illegal
//   in_funct3        funct3 field
//   in_alt           instr[30] select (SUB / SRA / SRAI)
//   in_rd/rs1/rs2    register fields
//   in_imm           byte offset / immediate, two's complement
//   out_valid/ready  encoded-word handshake
//   out_instr        encoded instruction word
//   out_error        out_instr is NOP_WORD because the descriptor was illegal
//   enc_count        accepted descriptors including errors, wraps
//   err_count        accepted illegal descriptors, saturates at 255

module rv32i_instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_error,
  output logic [CNT_W-1:0] enc_count,
  output logic [7:0]       err_count
);

  // Descriptor classes
  localparam logic [3:0] CLS_LOAD   = 4'd0;
  localparam logic [3:0] CLS_OP_IMM = 4'd1;
  localparam logic [3:0] CLS_AUIPC  = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_OP     = 4'd4;
  localparam logic [3:0] CLS_LUI    = 4'd5;
  localparam logic [3:0] CLS_BRANCH = 4'd6;
  localparam logic [3:0] CLS_JALR   = 4'd7;
  localparam logic [3:0] CLS_JAL    = 4'd8;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Format builders. Each takes only the immediate bits its format carries.
  function automatic logic [31:0] fmt_i(input logic [11:0] imm12,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  f3,
                                        input logic [4:0]  rd,
                                        input logic [6:0]  op);
    return {imm12, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [11:0] imm12,
                                        input logic [4:0]  rs2,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  f3,
                                        input logic [6:0]  op);
    return {imm12[11:5], rs2, rs1, f3, imm12[4:0], op};
  endfunction

  function automatic logic [31:0] fmt_b(input logic [12:1] off,
                                        input logic [4:0]  rs2,
                                        input logic [4:0]  rs1,
                                        input logic [2:0]  f3,
                                        input logic [6:0]  op);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], op};
  endfunction

  function automatic logic [31:0] fmt_u(input logic [31:12] upper,
                                        input logic [4:0]   rd,
                                        input logic [6:0]   op);
    return {upper, rd, op};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [20:1] off,
                                        input logic [4:0]  rd,
                                        input logic [6:0]  op);
    return {off[20], off[10:1], off[11], off[19:12], rd, op};
  endfunction

  function automatic logic [31:0] fmt_r(input logic       alt,
                                        input logic [4:0] rs2,
                                        input logic [4:0] rs1,
                                        input logic [2:0] f3,
                                        input logic [4:0] rd,
                                        input logic [6:0] op);
    return {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, op};
  endfunction

  // A value fits an N-bit signed field when every bit from N-1 upward
  // equals the sign bit.
  logic imm_fits12;
  logic imm_fits13;
  logic imm_fits21;
  logic shamt_ok;
  logic upper_ok;
  logic is_shift;

  assign imm_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign imm_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign imm_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign shamt_ok   = ~(|in_imm[31:5]);
  assign upper_ok   = ~(|in_imm[11:0]);
  // SLLI (001) and SRLI/SRAI (101) carry a 5-bit shift amount.
  assign is_shift   = (in_funct3[1:0] == 2'b01);

  logic [31:0] enc_word;
  logic        field_ok;
  logic        alt_ok;
  logic        enc_ok;

  // Builds the word for the requested class and decides whether its funct3
  // and immediate are legal. alt_ok lists the only encodings where
  // instr[30] has meaning; alt=1 anywhere else is an error.
  always_comb begin
    enc_word = '0;
    field_ok = 1'b0;
    alt_ok   = 1'b0;
    case (in_class)
      CLS_LOAD: begin
        enc_word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD);
        field_ok = (in_funct3 != 3'b011) && (in_funct3 != 3'b110) &&
                   (in_funct3 != 3'b111) && imm_fits12;
      end
      CLS_OP_IMM: begin
        if (is_shift) begin
          enc_word = fmt_i({1'b0, in_alt, 5'b00000, in_imm[4:0]},
                           in_rs1, in_funct3, in_rd, OPC_OP_IMM);
          field_ok = shamt_ok;
          alt_ok   = in_funct3[2];
        end else begin
          enc_word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OP_IMM);
          field_ok = imm_fits12;
        end
      end
      CLS_AUIPC: begin
        enc_word = fmt_u(in_imm[31:12], in_rd, OPC_AUIPC);
        field_ok = upper_ok;
      end
      CLS_STORE: begin
        enc_word = fmt_s(in_imm[11:0], in_rs2, in_rs1, in_funct3, OPC_STORE);
        field_ok = (in_funct3[2] == 1'b0) && (in_funct3[1:0] != 2'b11) &&
                   imm_fits12;
      end
      CLS_OP: begin
        enc_word = fmt_r(in_alt, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP);
        field_ok = 1'b1;
        alt_ok   = (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
      end
      CLS_LUI: begin
        enc_word = fmt_u(in_imm[31:12], in_rd, OPC_LUI);
        field_ok = upper_ok;
      end
      CLS_BRANCH: begin
        enc_word = fmt_b(in_imm[12:1], in_rs2, in_rs1, in_funct3, OPC_BRANCH);
        field_ok = (in_funct3[2:1] != 2'b01) && !in_imm[0] && imm_fits13;
      end
      CLS_JALR: begin
        enc_word = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR);
        field_ok = (in_funct3 == 3'b000) && imm_fits12;
      end
      CLS_JAL: begin
        enc_word = fmt_j(in_imm[20:1], in_rd, OPC_JAL);
        field_ok = !in_imm[0] && imm_fits21;
      end
      default: begin
        enc_word = '0;
        field_ok = 1'b0;
      end
    endcase
    enc_ok = field_ok && (!in_alt || alt_ok);
  end

  logic accept;

  // The output slot can take a new word when it is empty or being drained
  // this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register and counters. An accept always reloads the slot, which
  // also covers a pop in the same cycle; a pop alone just empties it.
  // out_instr/out_error keep their last value while the slot is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_error <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_ok ? enc_word : NOP_WORD;
        out_error <= !enc_ok;
        enc_count <= enc_count + CNT_W'(1);
        if (!enc_ok && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
